// File: rtl/conv_mem_pkg.sv
// rtl/conv_mem_pkg.sv - shared constants and word-index helper for the conv memory responder
package conv_mem_pkg;

  localparam int DATA_W    = 32;
  localparam int IMG_WORDS = 784;
  localparam int WGT_BASE  = 784;
  localparam int WGT_WORDS = 9;
  localparam int BIAS_WORD = 793;
  localparam int BE_W      = 4;

  // Byte address to word index; callers zero-extend their address to 64 bits.
  function automatic logic [63:0] word_idx(input logic [63:0] byte_addr);
    return byte_addr >> 2;
  endfunction

endpackage

// File: rtl/conv_mem_responder_if.sv
// rtl/conv_mem_responder_if.sv - dp request bus between the datapath and a memory responder
interface conv_mem_responder_if #(
  parameter int ADDR_W = 32
);
  import conv_mem_pkg::*;

  logic              R_req;
  logic [ADDR_W-1:0] addr;
  logic [BE_W-1:0]   W_req;
  logic [DATA_W-1:0] W_data;
  logic [DATA_W-1:0] R_data;
  logic              R_valid;

  modport master (
    output R_req, addr, W_req, W_data,
    input  R_data, R_valid
  );

  modport slave (
    input  R_req, addr, W_req, W_data,
    output R_data, R_valid
  );
endinterface

// File: rtl/conv_mem_responder_rd_pipe.sv
// rtl/conv_mem_responder_rd_pipe.sv - fixed-latency read return pipeline with synchronous flush
module mem_rd_pipe #(
  parameter int LAT = 1,
  parameter int W   = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [LAT-1:0] vld;
  logic [W-1:0]   dat [LAT];

  // Shift {valid, data} one stage per cycle; data is forced to 0 whenever its valid is 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld <= '0;
      for (int i = 0; i < LAT; i++) begin
        dat[i] <= '0;
      end
    end else begin
      vld[0] <= in_valid;
      dat[0] <= in_valid ? in_data : '0;
      for (int i = 1; i < LAT; i++) begin
        vld[i] <= vld[i-1];
        dat[i] <= dat[i-1];
      end
    end
  end

  assign out_valid = vld[LAT-1];
  assign out_data  = dat[LAT-1];

endmodule

// File: rtl/conv_mem_responder.sv
// rtl/conv_mem_responder.sv - word-addressed bank serving dp reads, byte-lane writes and preloads
module conv_mem_responder
  import conv_mem_pkg::*;
#(
  parameter int DEPTH    = 1024,
  parameter int READ_LAT = 1,
  parameter int ADDR_W   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  conv_mem_responder_if.slave  bus,
  input  logic                 ld_en,
  input  logic [ADDR_W-1:0]    ld_addr,
  input  logic [DATA_W-1:0]    ld_data,
  output logic                 err,
  output logic [15:0]          rd_cnt,
  output logic [15:0]          wr_cnt
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] bank [DEPTH];

  logic [63:0]       a_widx;
  logic [63:0]       l_widx;
  logic              a_legal;
  logic              l_legal;
  logic              wr_any;
  logic [DATA_W-1:0] rd_word;

  // Legality decode for the shared request address and the preload address.
  always_comb begin
    a_widx  = word_idx(64'(bus.addr));
    l_widx  = word_idx(64'(ld_addr));
    a_legal = (bus.addr[1:0] == 2'b00) && (a_widx < 64'(DEPTH));
    l_legal = (ld_addr[1:0] == 2'b00) && (l_widx < 64'(DEPTH));
    wr_any  = |bus.W_req;
    rd_word = '0;
    if (bus.R_req && a_legal) begin
      rd_word = bank[a_widx[IDX_W-1:0]];
    end
  end

  // Bank update: byte-lane write first, preload last so it wins on a same-word collision.
  always_ff @(posedge clk) begin
    if (wr_any && a_legal) begin
      for (int i = 0; i < BE_W; i++) begin
        if (bus.W_req[i]) begin
          bank[a_widx[IDX_W-1:0]][8*i +: 8] <= bus.W_data[8*i +: 8];
        end
      end
    end
    if (ld_en && l_legal) begin
      bank[l_widx[IDX_W-1:0]] <= ld_data;
    end
  end

  // Saturating operation counters and the sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
      err    <= 1'b0;
    end else begin
      if (bus.R_req && (rd_cnt != 16'hFFFF)) begin
        rd_cnt <= rd_cnt + 16'd1;
      end
      if (wr_any && (wr_cnt != 16'hFFFF)) begin
        wr_cnt <= wr_cnt + 16'd1;
      end
      if ((bus.R_req && !a_legal) || (wr_any && !a_legal) || (ld_en && !l_legal)) begin
        err <= 1'b1;
      end
    end
  end

  mem_rd_pipe #(
    .LAT (READ_LAT),
    .W   (DATA_W)
  ) u_rd_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (bus.R_req),
    .in_data   (rd_word),
    .out_valid (bus.R_valid),
    .out_data  (bus.R_data)
  );

endmodule

// File: tb/tb_conv_mem_responder.sv
// tb/tb_conv_mem_responder.sv - self-checking bench for conv_mem_responder at READ_LAT 1 and 3
module tb_conv_mem_responder;
  import conv_mem_pkg::*;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        r_req;
  logic [31:0] addr;
  logic [3:0]  w_req;
  logic [31:0] w_data;
  logic        ld_en;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;

  logic        err1, err3;
  logic [15:0] rd_cnt1, rd_cnt3, wr_cnt1, wr_cnt3;

  int checks   = 0;
  int failures = 0;

  conv_mem_responder_if #(.ADDR_W(32)) bus1 ();
  conv_mem_responder_if #(.ADDR_W(32)) bus3 ();

  assign bus1.R_req  = r_req;
  assign bus1.addr   = addr;
  assign bus1.W_req  = w_req;
  assign bus1.W_data = w_data;
  assign bus3.R_req  = r_req;
  assign bus3.addr   = addr;
  assign bus3.W_req  = w_req;
  assign bus3.W_data = w_data;

  conv_mem_responder #(.DEPTH(DEPTH), .READ_LAT(1), .ADDR_W(32)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data), .err(err1), .rd_cnt(rd_cnt1), .wr_cnt(wr_cnt1)
  );

  conv_mem_responder #(.DEPTH(DEPTH), .READ_LAT(3), .ADDR_W(32)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data), .err(err3), .rd_cnt(rd_cnt3), .wr_cnt(wr_cnt3)
  );

  always #5 clk = ~clk;

  // Reference model: a plain word array, per-latency queues of expected returns, counters.
  typedef struct {
    int          due;
    logic [31:0] d;
  } rsp_t;

  logic [31:0] mbank [DEPTH];
  rsp_t        q1[$];
  rsp_t        q3[$];
  int          cyc = 0;
  bit          started = 0;
  logic        m_err;
  logic [15:0] m_rd, m_wr;

  function automatic bit m_legal(input logic [31:0] a);
    return (a % 4 == 0) && (a / 4 < DEPTH);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) begin
    logic [31:0] d;
    logic [31:0] w;
    cyc++;
    if (reset) begin
      q1.delete();
      q3.delete();
      m_err   = 1'b0;
      m_rd    = 16'd0;
      m_wr    = 16'd0;
      started = 1;
    end else begin
      if (r_req) begin
        d = m_legal(addr) ? mbank[addr / 4] : 32'd0;
        q1.push_back('{due: cyc, d: d});
        q3.push_back('{due: cyc + 2, d: d});
        if (m_rd < 16'hFFFF) m_rd++;
        if (!m_legal(addr)) m_err = 1'b1;
      end
      if (w_req != 4'd0) begin
        if (m_wr < 16'hFFFF) m_wr++;
        if (!m_legal(addr)) m_err = 1'b1;
      end
      if (ld_en && !m_legal(ld_addr)) m_err = 1'b1;
    end
    if (w_req != 4'd0 && m_legal(addr)) begin
      w = mbank[addr / 4];
      for (int i = 0; i < 4; i++) begin
        if (w_req[i]) w[8*i +: 8] = w_data[8*i +: 8];
      end
      mbank[addr / 4] = w;
    end
    if (ld_en && m_legal(ld_addr)) mbank[ld_addr / 4] = ld_data;
  end

  // Every-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    bit          ev1, ev3;
    logic [31:0] ed1, ed3;
    if (started) begin
      ev1 = (q1.size() > 0) && (q1[0].due == cyc);
      ed1 = ev1 ? q1[0].d : 32'd0;
      if (ev1) void'(q1.pop_front());
      ev3 = (q3.size() > 0) && (q3[0].due == cyc);
      ed3 = ev3 ? q3[0].d : 32'd0;
      if (ev3) void'(q3.pop_front());
      chk("lat1_valid", 32'(bus1.R_valid), 32'(ev1));
      chk("lat1_data", bus1.R_data, ed1);
      chk("lat3_valid", 32'(bus3.R_valid), 32'(ev3));
      chk("lat3_data", bus3.R_data, ed3);
      chk("err1", 32'(err1), 32'(m_err));
      chk("err3", 32'(err3), 32'(m_err));
      chk("rd_cnt1", 32'(rd_cnt1), 32'(m_rd));
      chk("rd_cnt3", 32'(rd_cnt3), 32'(m_rd));
      chk("wr_cnt1", 32'(wr_cnt1), 32'(m_wr));
      chk("wr_cnt3", 32'(wr_cnt3), 32'(m_wr));
    end
  end

  task automatic idle();
    r_req = 0; addr = 0; w_req = 0; w_data = 0;
    ld_en = 0; ld_addr = 0; ld_data = 0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    step();
    reset = 0;
  endtask

  task automatic preload(input int word, input logic [31:0] data);
    idle();
    ld_en = 1; ld_addr = 32'(word * 4); ld_data = data;
    step();
    idle();
  endtask

  // Single read on the LAT=1 instance, checked against a hand-computed literal.
  task automatic rd_lit(input string name, input logic [31:0] a, input logic [31:0] exp);
    idle();
    r_req = 1; addr = a;
    step();
    chk({name, "_valid"}, 32'(bus1.R_valid), 32'd1);
    chk({name, "_data"}, bus1.R_data, exp);
    idle();
  endtask

  initial begin
    idle();
    reset = 1;
    step();
    step();
    reset = 0;

    for (int i = 0; i < DEPTH; i++) begin
      ld_en = 1; ld_addr = 32'(i * 4); ld_data = $urandom;
      step();
    end
    idle();
    step();

    // T1: reset with reads in flight
    preload(5, 32'hDEADBEEF);
    r_req = 1; addr = 20;
    step();
    idle();
    reset = 1;
    step();
    reset = 0;
    chk("t1_valid3", 32'(bus3.R_valid), 32'd0);
    chk("t1_data3", bus3.R_data, 32'd0);
    chk("t1_err", 32'(err1), 32'd0);
    chk("t1_rd_cnt", 32'(rd_cnt1), 32'd0);
    step();
    chk("t1_flushed3", 32'(bus3.R_valid), 32'd0);
    rd_lit("t1_reread", 32'd20, 32'hDEADBEEF);
    step(); step(); step();

    // T2: latency sweep
    do_reset();
    preload(0, 32'd1);
    preload(1, 32'd2);
    preload(2, 32'd3);
    r_req = 1; addr = 0;
    step();
    chk("t2_l1_d0", bus1.R_data, 32'd1);
    chk("t2_l3_early", 32'(bus3.R_valid), 32'd0);
    addr = 4;
    step();
    chk("t2_l1_d1", bus1.R_data, 32'd2);
    addr = 8;
    step();
    chk("t2_l1_d2", bus1.R_data, 32'd3);
    chk("t2_l3_d0", bus3.R_data, 32'd1);
    idle();
    step();
    chk("t2_l3_d1", bus3.R_data, 32'd2);
    chk("t2_l1_done", 32'(bus1.R_valid), 32'd0);
    step();
    chk("t2_l3_d2", bus3.R_data, 32'd3);
    chk("t2_rd_cnt", 32'(rd_cnt3), 32'd3);
    step();
    chk("t2_l3_done", 32'(bus3.R_valid), 32'd0);

    // T3: byte-lane write
    preload(BIAS_WORD, 32'h11223344);
    w_req = 4'b0101; addr = 32'(BIAS_WORD * 4); w_data = 32'hAABBCCDD;
    step();
    idle();
    chk("t3_wr_cnt", 32'(wr_cnt1), 32'd1);
    rd_lit("t3_merge", 32'(BIAS_WORD * 4), 32'h11BB33DD);

    // T4: read and write to the same word in one cycle
    preload(WGT_BASE, 32'd7);
    r_req = 1; w_req = 4'hF; addr = 32'd3136; w_data = 32'd9;
    step();
    chk("t4_old", bus1.R_data, 32'd7);
    idle();
    rd_lit("t4_new", 32'd3136, 32'd9);

    // T5: illegal accesses
    rd_lit("t5_misaligned", 32'd6, 32'd0);
    chk("t5_err", 32'(err1), 32'd1);
    w_req = 4'hF; addr = 32'(DEPTH * 4); w_data = 32'h5A5A5A5A;
    step();
    idle();
    chk("t5_err_stays", 32'(err3), 32'd1);

    // T6: preload collides with a write
    ld_en = 1; ld_addr = 40; ld_data = 32'd1;
    w_req = 4'hF; addr = 40; w_data = 32'd2;
    step();
    idle();
    rd_lit("t6_ld_wins", 32'd40, 32'd1);

    // Randomized traffic including misaligned/out-of-range addresses and occasional resets
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      int sel;
      idle();
      if ($urandom_range(199) == 0) begin
        reset = 1;
      end else begin
        reset = 0;
        sel = $urandom_range(15);
        r_req = ($urandom_range(1) == 1);
        addr  = (sel == 0) ? $urandom_range(4 * DEPTH + 200) :
                (sel == 1) ? 32'($urandom_range(DEPTH + 50) * 4) :
                             32'($urandom_range(DEPTH - 1) * 4);
        w_req  = ($urandom_range(2) == 0) ? 4'($urandom) : 4'd0;
        w_data = $urandom;
        ld_en  = ($urandom_range(3) == 0);
        ld_addr = ($urandom_range(9) == 0) ? $urandom_range(4 * DEPTH + 200) :
                  ($urandom_range(1) == 0) ? addr : 32'($urandom_range(DEPTH - 1) * 4);
        ld_data = $urandom;
      end
      step();
    end
    idle();
    reset = 0;

    // Counter saturation
    do_reset();
    for (int n = 0; n < 65540; n++) begin
      r_req = 1; w_req = 4'hF; addr = 0; w_data = $urandom;
      step();
    end
    idle();
    chk("sat_rd_cnt", 32'(rd_cnt1), 32'h0000FFFF);
    chk("sat_wr_cnt", 32'(wr_cnt3), 32'h0000FFFF);
    step(); step(); step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
